char_motion_ctrl: RTL
=====================

CHAR_MOTION_CTRL -- requirements
Module: char_motion_ctrl

Interface
REQ-001 SHALL have parameter COORD_W, default 10, coordinate width in bits.
REQ-002 SHALL have parameters INIT_X 80, INIT_Y 340, MIN_X 40, MAX_X 600, CHAR_WIDTH 128: start position, left bound, right screen edge, sprite width.
REQ-003 SHALL have parameters STEP_L 2 and STEP_R 3, pixels moved per frame_tick when walking left or right.
REQ-004 SHALL have parameters KB_STEP 4 and KB_FRAMES 8, knockback pixels per tick and knockback duration in ticks.
REQ-005 Ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-006 Ports: state in 4, character state code (IDLE 0, LEFT 1, RIGHT 2, attack codes 3-8); frame_tick in 1, one-cycle movement strobe.
REQ-007 Ports: collision_flag in 1, characters touching; char_no in 1, 0 = left-side player, 1 = right-side player; hit_flag in 1, one-cycle pulse marking this character as hit.
REQ-008 Ports: char_x out COORD_W, left edge x; char_y out COORD_W, top edge y; kb_active out 1, knockback in progress; moving out 1, char_x changed on the last tick.

Function
REQ-009 SHALL update positions only in cycles where frame_tick=1; all other cycles hold char_x.
REQ-010 SHALL hold char_y at INIT_Y at all times.
REQ-011 SHALL implement a two-state FSM, WALK and KNOCK, with a KB_FRAMES-range tick counter.
REQ-012 In WALK with state=LEFT on a tick: move by -STEP_L unless char_no=1 and collision_flag=1.
REQ-013 In WALK with state=RIGHT on a tick: move by +STEP_R unless char_no=0 and collision_flag=1.
REQ-014 In WALK with any other state code: hold char_x.
REQ-015 Clamp every move to [MIN_X, MAX_X-CHAR_WIDTH].
REQ-016 Compute every move in COORD_W+1 signed bits so that left moves never wrap below zero.
REQ-017 When hit_flag=1 in any cycle: enter KNOCK and load counter=KB_FRAMES; a hit while already in KNOCK reloads the counter.
REQ-018 In KNOCK on each tick: move by KB_STEP away from the opponent (char_no 0: -KB_STEP; char_no 1: +KB_STEP), ignore state and collision_flag, clamp per REQ-015, and decrement the counter.
REQ-019 When the tick decrements the counter to 0: return to WALK on the next cycle.
REQ-020 When hit_flag and frame_tick coincide: load the counter; that tick moves using knockback rules and does not decrement.
REQ-021 kb_active SHALL equal (FSM==KNOCK) and be registered.
REQ-022 moving SHALL be registered on each tick as (new char_x != old char_x) and held between ticks.
REQ-023 Output latency SHALL be one clock from the frame_tick edge to the updated char_x.

Reset
REQ-024 While rst_n=0, asynchronously: char_x=INIT_X, char_y=INIT_Y, FSM=WALK, counter=0, kb_active=0, moving=0.
REQ-025 Reset asserted mid-knockback SHALL abort the knockback; the first tick after release obeys WALK rules.

Structure
REQ-026 State codes S_IDLE..S_ATTACK_DIR_RECOVERY SHALL live in shared package game_pkg, together with the FSM encoding for WALK/KNOCK.
REQ-027 Clamping SHALL be one sub-module, pos_clamp (signed COORD_W+1 input, MIN/MAX parameters, COORD_W output), instantiated once.
REQ-028 The design SHALL contain no combinational path from inputs to outputs.

Verification
REQ-029 Walk-left to bound: char_x=44, state=LEFT, 3 ticks -> 42, 40, 40; moving 1, 1, 0.
REQ-030 Right-edge clamp: char_x=470, state=RIGHT, tick -> 472; next tick -> 472.
REQ-031 Collision block: char_no=0, collision_flag=1, state=RIGHT, tick -> char_x unchanged. Same setup with state=LEFT, tick -> char_x-2.
REQ-032 Knockback: char_no=1, char_x=300, hit_flag pulse, then 8 ticks with state=LEFT -> char_x=332, kb_active high for 8 ticks then low. The 9th tick -> 330.
REQ-033 Re-hit: hit at tick 5 of a knockback -> kb_active lasts 8 further ticks; coincident hit_flag and frame_tick moves on that tick without decrementing.
REQ-034 Async reset: drop rst_n mid-knockback between clock edges -> outputs at reset values immediately; underflow check: MIN_X=0, char_x=1, LEFT tick -> 0, not wrapped.

Source files
------------

// File: rtl/game_pkg.sv
// Shared character state codes and the motion FSM encoding used by the
// character controllers.
package game_pkg;

  typedef enum logic [3:0] {
    S_IDLE                = 4'd0,
    S_LEFT                = 4'd1,
    S_RIGHT               = 4'd2,
    S_ATTACK_START        = 4'd3,
    S_ATTACK_ACTIVE       = 4'd4,
    S_ATTACK_RECOVERY     = 4'd5,
    S_ATTACK_DIR_START    = 4'd6,
    S_ATTACK_DIR_ACTIVE   = 4'd7,
    S_ATTACK_DIR_RECOVERY = 4'd8
  } char_state_t;

  typedef enum logic {
    MOT_WALK  = 1'b0,
    MOT_KNOCK = 1'b1
  } motion_state_t;

endpackage

// File: rtl/pos_clamp.sv
// Saturates a signed candidate position into the unsigned window [MIN, MAX].
module pos_clamp #(
  parameter int COORD_W = 10,
  parameter int MIN     = 40,
  parameter int MAX     = 472
) (
  input  logic signed [COORD_W:0]   pos_in,
  output logic        [COORD_W-1:0] pos_out
);

  localparam logic signed [COORD_W:0] MIN_S = (COORD_W+1)'(MIN);
  localparam logic signed [COORD_W:0] MAX_S = (COORD_W+1)'(MAX);

  // Saturate against both bounds; negative candidates land on MIN.
  always_comb begin
    pos_out = MIN_S[COORD_W-1:0];
    if (pos_in < MIN_S) begin
      pos_out = MIN_S[COORD_W-1:0];
    end else if (pos_in > MAX_S) begin
      pos_out = MAX_S[COORD_W-1:0];
    end else begin
      pos_out = pos_in[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/char_motion_ctrl.sv
// Horizontal motion of one fighter: walking on frame ticks, collision
// blocking, and timed knockback after a hit. All outputs are registered.
module char_motion_ctrl
  import game_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int INIT_X     = 80,
  parameter int INIT_Y     = 340,
  parameter int MIN_X      = 40,
  parameter int MAX_X      = 600,
  parameter int CHAR_WIDTH = 128,
  parameter int STEP_L     = 2,
  parameter int STEP_R     = 3,
  parameter int KB_STEP    = 4,
  parameter int KB_FRAMES  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         state,
  input  logic               frame_tick,
  input  logic               collision_flag,
  input  logic               char_no,
  input  logic               hit_flag,
  output logic [COORD_W-1:0] char_x,
  output logic [COORD_W-1:0] char_y,
  output logic               kb_active,
  output logic               moving
);

  localparam int CNT_W = $clog2(KB_FRAMES + 1);
  localparam logic [CNT_W-1:0] KB_LOAD = CNT_W'(KB_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic signed [COORD_W:0] D_LEFT  = (COORD_W+1)'(-STEP_L);
  localparam logic signed [COORD_W:0] D_RIGHT = (COORD_W+1)'(STEP_R);
  localparam logic signed [COORD_W:0] D_KB_L  = (COORD_W+1)'(-KB_STEP);
  localparam logic signed [COORD_W:0] D_KB_R  = (COORD_W+1)'(KB_STEP);
  localparam logic signed [COORD_W:0] D_ZERO  = (COORD_W+1)'(0);

  motion_state_t             fsm_r, fsm_nxt_s;
  logic [CNT_W-1:0]          cnt_r, cnt_nxt_s;
  logic [COORD_W-1:0]        char_x_r, char_y_r, x_nxt_s, clamped_s;
  logic                      kb_active_r, moving_r, kb_nxt_s, moving_nxt_s;
  logic signed [COORD_W:0]   delta_s, sum_s;

  // Motion FSM state and knockback tick counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r <= MOT_WALK;
      cnt_r <= '0;
    end else begin
      fsm_r <= fsm_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  // A hit always (re)loads the counter; otherwise knockback ticks count down.
  always_comb begin
    fsm_nxt_s = fsm_r;
    cnt_nxt_s = cnt_r;
    if (hit_flag) begin
      fsm_nxt_s = MOT_KNOCK;
      cnt_nxt_s = KB_LOAD;
    end else if ((fsm_r == MOT_KNOCK) && frame_tick) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
      if (cnt_r <= CNT_ONE) begin
        fsm_nxt_s = MOT_WALK;
      end else begin
        fsm_nxt_s = MOT_KNOCK;
      end
    end else begin
      fsm_nxt_s = fsm_r;
      cnt_nxt_s = cnt_r;
    end
  end

  // Per-tick displacement; a coincident hit already moves by knockback rules.
  always_comb begin
    delta_s = D_ZERO;
    if (hit_flag || (fsm_r == MOT_KNOCK)) begin
      delta_s = char_no ? D_KB_R : D_KB_L;
    end else begin
      case (state)
        S_LEFT:  delta_s = (char_no && collision_flag) ? D_ZERO : D_LEFT;
        S_RIGHT: delta_s = (!char_no && collision_flag) ? D_ZERO : D_RIGHT;
        default: delta_s = D_ZERO;
      endcase
    end
  end

  assign sum_s = $signed({1'b0, char_x_r}) + delta_s;

  pos_clamp #(
    .COORD_W (COORD_W),
    .MIN     (MIN_X),
    .MAX     (MAX_X - CHAR_WIDTH)
  ) u_clamp (
    .pos_in  (sum_s),
    .pos_out (clamped_s)
  );

  // Next output values; position and moving only change on a tick.
  always_comb begin
    kb_nxt_s     = (fsm_nxt_s == MOT_KNOCK);
    x_nxt_s      = char_x_r;
    moving_nxt_s = moving_r;
    if (frame_tick) begin
      x_nxt_s      = clamped_s;
      moving_nxt_s = (clamped_s != char_x_r);
    end else begin
      x_nxt_s      = char_x_r;
      moving_nxt_s = moving_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_x_r    <= COORD_W'(INIT_X);
      char_y_r    <= COORD_W'(INIT_Y);
      kb_active_r <= 1'b0;
      moving_r    <= 1'b0;
    end else begin
      char_x_r    <= x_nxt_s;
      char_y_r    <= COORD_W'(INIT_Y);
      kb_active_r <= kb_nxt_s;
      moving_r    <= moving_nxt_s;
    end
  end

  assign char_x    = char_x_r;
  assign char_y    = char_y_r;
  assign kb_active = kb_active_r;
  assign moving    = moving_r;

endmodule
